cpu_run_controller: RTL and testbench
=====================================

// Module: cpu_run_controller
// PURPOSE
//  Sequencer for the 3-bit single-cycle CPU. Loads a program from a host word stream into
//  CPU RAM, pulses the CPU reset, then runs, single-steps or halts the CPU through its
//  PC_Enable gate. Halt sources: host command, PC breakpoint, cycle-limit counter.
//  Sits between the host/testbench and the CPU top level.
// PARAMETERS
//  ADDR_W  3  RAM/PC address width
//  DATA_W  9  instruction word width
//  DEPTH   8  RAM rows; load auto-completes after DEPTH words
//  CNT_W   8  cycle counter / limit width
// PORTS
//  clk          in   1       single clock, rising edge
//  reset        in   1       synchronous, active-low
//  host_valid   in   1       host word valid
//  host_ready   out  1       controller accepts word (LOAD only)
//  host_data    in   DATA_W  program word
//  host_last    in   1       final word of program
//  cmd_load     in   1       start load (IDLE/HALT only)
//  cmd_run      in   1       run / resume (IDLE/HALT only)
//  cmd_step     in   1       execute one instruction (IDLE/HALT only)
//  cmd_halt     in   1       stop RUN
//  pc_i         in   ADDR_W  current CPU PC
//  bkpt_valid   in   1       breakpoint armed
//  bkpt_addr    in   ADDR_W  breakpoint PC
//  cycle_limit  in   CNT_W   max enabled cycles per run; 0 = unlimited
//  ram_wr_data  out  DATA_W  to CPU RAM_Write_Data
//  ram_wr_addr  out  ADDR_W  to CPU RAM_Write_Address
//  ram_wr_en    out  1       to CPU RAM_Write_Enable
//  cpu_reset    out  1       active-high CPU reset
//  pc_enable    out  1       to CPU PC_Enable
//  state_o      out  3       FSM state code
//  halt_cause   out  2       00 CMD, 01 BKPT, 10 LIMIT, 11 STEP
//  cycle_count  out  CNT_W   enabled cycles in current run
// BEHAVIOUR
//  Reset (reset==0 at posedge): state IDLE, wr_ptr 0, cycle_count 0, halt_cause 00,
//   ram_wr_en 0, host_ready 0, pc_enable 0 within half a cycle; cpu_reset = ~reset | (state==CLR).
//   Reset mid-LOAD/RUN aborts immediately; a partial load is not resumed.
//  States: IDLE -> LOAD (cmd_load); LOAD -> CLR (DEPTH-th word or host_last accepted);
//   CLR -> IDLE after 1 cycle; IDLE/HALT -> RUN (cmd_run) or STEP (cmd_step);
//   RUN -> HALT on halt event; STEP -> HALT after 1 enabled cycle, cause 11.
//  Simultaneous commands: cmd_load > cmd_run > cmd_step. Commands in other states are ignored.
//  LOAD: host_ready=1; on valid&ready, ram_wr_en=1 combinationally, ram_wr_addr=wr_ptr,
//   ram_wr_data=host_data; wr_ptr increments, wrapping DEPTH-1 -> 0. wr_ptr clears on entering LOAD.
//  pc_enable: run_en = (state==RUN && no halt event) || state==STEP, registered at posedge and
//   re-timed on negedge clk, so the AND-gated CPU clock never glitches. 1 enabled cycle = 1 instr.
//  cycle_count: cleared on IDLE->RUN/STEP, kept on HALT->RUN/STEP; +1 per enabled cycle,
//   saturates at all-ones.
//  Halt events in RUN, evaluated every cycle before enabling; priority cmd_halt(00) >
//   bkpt(01) > limit(10):
//   bkpt: bkpt_valid && pc_i==bkpt_addr; the CPU stops with PC at bkpt, instruction unexecuted.
//   limit: cycle_limit!=0 && cycle_count==cycle_limit.
//  Resume skip: the first cycle after HALT->RUN ignores a bkpt match, so resuming from a bkpt
//   advances.
//  cmd_halt in STEP is ignored; the step completes.
// CONFIGURATION
//  CPU_CTRL_BKPT_EN defined: breakpoint logic as above.
//  Not defined: bkpt_valid/bkpt_addr ports kept but ignored; halt_cause 01 is never produced.
// STRUCTURE
//  cpu_ctrl_pkg: state encoding (IDLE=0, LOAD=1, CLR=2, RUN=3, STEP=4, HALT=5),
//   HALT_CMD/BKPT/LIMIT/STEP codes, default widths.
//  Sub-module cpu_clk_gate: negedge re-timing flop for pc_enable, cleared by reset.
// TESTING
//  Reset low mid-RUN -> next edge state 0, pc_enable 0 by the following negedge, cpu_reset 1.
//  cmd_load, 3 words then host_last -> writes at addr 0,1,2; CLR for 1 cycle (cpu_reset=1);
//   then IDLE; 9 words without last -> 8 written, then CLR.
//  cmd_run, cycle_limit=5 -> exactly 5 pc_enable cycles, HALT, cause 10, cycle_count 5.
//  BKPT_EN, bkpt_addr=3, program counting 0..7 -> HALT with pc_i=3, cause 01; cmd_run ->
//   passes 3 and continues.
//  cmd_step x2 from HALT -> 1 enabled cycle each, cause 11, cycle_count +1 each.
//  cmd_load+cmd_run same cycle in IDLE -> LOAD; cmd_halt with bkpt match same cycle -> cause 00.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared definitions for the CPU run controller.
//   state_t      - controller FSM state codes (visible on state_o)
//   halt_cause_t - reason for the most recent halt (visible on halt_cause)
//   *_DEF        - default parameter widths/depth
package cpu_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned DATA_W_DEF = 9;
  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CLR  = 3'd2,
    ST_RUN  = 3'd3,
    ST_STEP = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    HALT_CMD   = 2'b00,
    HALT_BKPT  = 2'b01,
    HALT_LIMIT = 2'b10,
    HALT_STEP  = 2'b11
  } halt_cause_t;

endpackage

// File: rtl/cpu_clk_gate.sv
// cpu_clk_gate: re-times the run enable onto the falling clock edge so that
// an AND-gated CPU clock (clk & o_en) only changes while clk is low.
//   clk   in  controller clock
//   reset in  synchronous active-low reset (clears the enable)
//   i_en  in  run enable computed in the current cycle
//   o_en  out enable held from the falling edge through the next rising edge
module cpu_clk_gate (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_en
);

  logic r_en;

  always_ff @(negedge clk) begin
    if (!reset) r_en <= 1'b0;
    else        r_en <= i_en;
  end

  assign o_en = r_en;

endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: program loader and run/step/halt sequencer for the
// 3-bit single-cycle CPU.
//   Host side : host_valid/host_ready/host_data/host_last word stream,
//               cmd_load/cmd_run/cmd_step/cmd_halt commands.
//   CPU side  : ram_wr_data/ram_wr_addr/ram_wr_en program write port,
//               cpu_reset (active high), pc_enable gate, pc_i feedback.
//   Debug     : bkpt_valid/bkpt_addr breakpoint, cycle_limit (0 = none),
//               state_o, halt_cause, cycle_count.
//   clk, reset: rising-edge clock, synchronous active-low reset.
// Build option: define CPU_CTRL_BKPT_EN to enable the PC breakpoint; when
// undefined the breakpoint ports are accepted but have no effect.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_last,
  input  logic              cmd_load,
  input  logic              cmd_run,
  input  logic              cmd_step,
  input  logic              cmd_halt,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              bkpt_valid,
  input  logic [ADDR_W-1:0] bkpt_addr,
  input  logic [CNT_W-1:0]  cycle_limit,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic              ram_wr_en,
  output logic              cpu_reset,
  output logic              pc_enable,
  output logic [2:0]        state_o,
  output logic [1:0]        halt_cause,
  output logic [CNT_W-1:0]  cycle_count
);

  state_t            r_state;
  state_t            w_next;
  halt_cause_t       r_halt_cause;
  halt_cause_t       w_cause_next;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0]  r_cycle_count;
  logic              r_resume;
  logic              w_run_en;
  logic              w_wr_en;
  logic              w_ready;
  logic              w_bkpt_hit;
  logic              w_limit_hit;
  logic              w_halt_evt;

`ifdef CPU_CTRL_BKPT_EN
  // The first RUN cycle after a resume ignores the match so a halted
  // breakpoint can be stepped past.
  assign w_bkpt_hit = bkpt_valid && (pc_i == bkpt_addr) && !r_resume;
`else
  logic w_unused_bkpt;
  assign w_bkpt_hit    = 1'b0;
  assign w_unused_bkpt = ^{bkpt_valid, bkpt_addr, pc_i, r_resume};
`endif

  assign w_limit_hit = (cycle_limit != '0) && (r_cycle_count == cycle_limit);
  assign w_halt_evt  = cmd_halt || w_bkpt_hit || w_limit_hit;

  always_comb begin
    w_next       = r_state;
    w_cause_next = r_halt_cause;
    w_run_en     = 1'b0;
    w_wr_en      = 1'b0;
    w_ready      = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_HALT: begin
        if (cmd_load)      w_next = ST_LOAD;
        else if (cmd_run)  w_next = ST_RUN;
        else if (cmd_step) w_next = ST_STEP;
      end
      ST_LOAD: begin
        w_ready = 1'b1;
        if (host_valid) begin
          w_wr_en = 1'b1;
          if (host_last || (r_wr_ptr == ADDR_W'(DEPTH - 1))) w_next = ST_CLR;
        end
      end
      ST_CLR: w_next = ST_IDLE;
      ST_RUN: begin
        if (w_halt_evt) begin
          w_next = ST_HALT;
          if (cmd_halt)        w_cause_next = HALT_CMD;
          else if (w_bkpt_hit) w_cause_next = HALT_BKPT;
          else                 w_cause_next = HALT_LIMIT;
        end else begin
          w_run_en = 1'b1;
        end
      end
      ST_STEP: begin
        w_run_en     = 1'b1;
        w_next       = ST_HALT;
        w_cause_next = HALT_STEP;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_halt_cause  <= HALT_CMD;
      r_wr_ptr      <= '0;
      r_cycle_count <= '0;
      r_resume      <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_halt_cause <= w_cause_next;
      r_resume     <= (r_state == ST_HALT) && (w_next == ST_RUN);

      if ((r_state != ST_LOAD) && (w_next == ST_LOAD))
        r_wr_ptr <= '0;
      else if (w_wr_en)
        r_wr_ptr <= (r_wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + ADDR_W'(1);

      // A run started from IDLE is a fresh run; a resume from HALT keeps the total.
      if ((r_state == ST_IDLE) && ((w_next == ST_RUN) || (w_next == ST_STEP)))
        r_cycle_count <= '0;
      else if (w_run_en && (r_cycle_count != '1))
        r_cycle_count <= r_cycle_count + CNT_W'(1);
    end
  end

  cpu_clk_gate u_clk_gate (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_run_en),
    .o_en  (pc_enable)
  );

  assign host_ready  = w_ready;
  assign ram_wr_en   = w_wr_en;
  assign ram_wr_addr = r_wr_ptr;
  assign ram_wr_data = host_data;
  assign cpu_reset   = ~reset | (r_state == ST_CLR);
  assign state_o     = r_state;
  assign halt_cause  = r_halt_cause;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Randomized bench for cpu_run_controller with a counting-PC CPU stand-in
// and an instruction-level model of when each run halts and why.
module tb_cpu_run_controller;

`ifdef CPU_CTRL_BKPT_EN
  localparam bit BKPT_ON = 1'b1;
`else
  localparam bit BKPT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       host_valid = 1'b0;
  logic       host_ready;
  logic [8:0] host_data = '0;
  logic       host_last = 1'b0;
  logic       cmd_load = 1'b0, cmd_run = 1'b0, cmd_step = 1'b0, cmd_halt = 1'b0;
  logic [2:0] pc_i;
  logic       bkpt_valid = 1'b0;
  logic [2:0] bkpt_addr = '0;
  logic [7:0] cycle_limit = '0;
  logic [8:0] ram_wr_data;
  logic [2:0] ram_wr_addr;
  logic       ram_wr_en, cpu_reset, pc_enable;
  logic [2:0] state_o;
  logic [1:0] halt_cause;
  logic [7:0] cycle_count;

  cpu_run_controller #(.ADDR_W(3), .DATA_W(9), .DEPTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .host_valid(host_valid), .host_ready(host_ready),
    .host_data(host_data), .host_last(host_last), .cmd_load(cmd_load),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt), .pc_i(pc_i),
    .bkpt_valid(bkpt_valid), .bkpt_addr(bkpt_addr), .cycle_limit(cycle_limit),
    .ram_wr_data(ram_wr_data), .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en),
    .cpu_reset(cpu_reset), .pc_enable(pc_enable), .state_o(state_o),
    .halt_cause(halt_cause), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // CPU stand-in: PC counts once per gated clock edge, cleared by cpu_reset.
  logic [2:0]  cpu_pc = '0;
  int unsigned en_cnt = 0;
  logic [2:0]  wr_addr_q[$];
  logic [8:0]  wr_data_q[$];

  always @(posedge clk) begin
    if (cpu_reset) cpu_pc <= '0;
    else if (pc_enable) begin
      cpu_pc <= cpu_pc + 3'd1;
      en_cnt <= en_cnt + 1;
    end
    if (ram_wr_en) begin
      wr_addr_q.push_back(ram_wr_addr);
      wr_data_q.push_back(ram_wr_data);
    end
  end
  assign pc_i = cpu_pc;

  int vectors = 0;
  int miscompares = 0;
  int m_pc = 0;
  int m_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks the run one instruction at a time: k instructions executed so far,
  // PC = p+k, count = c0+k (saturating); stop on breakpoint before limit.
  function automatic void predict(input int p, input int c0, input int lim,
                                  input bit bv, input int b, input bit resume,
                                  output int n, output int cause);
    n = -1;
    cause = 0;
    for (int k = 0; k < 400; k++) begin
      int c;
      bit bk;
      c  = (c0 + k > 255) ? 255 : c0 + k;
      bk = BKPT_ON && bv && (((p + k) % 8) == b) && !(resume && k == 0);
      if (bk) begin n = k; cause = 1; return; end
      if (lim != 0 && c == lim) begin n = k; cause = 2; return; end
    end
  endfunction

  task automatic wait_halt(input string tag);
    int g = 0;
    while (state_o != 3'd5 && g < 300) begin
      tick();
      g++;
    end
    check({tag, "_halted"}, state_o, 5);
  endtask

  task automatic do_load(input int n, input bit use_last, input bit with_run);
    logic [8:0] sent[$];
    int k, w0;
    k  = (n > 8) ? 8 : n;
    w0 = wr_addr_q.size();
    cmd_load = 1'b1;
    cmd_run  = with_run;
    tick();
    cmd_load = 1'b0;
    cmd_run  = 1'b0;
    check("load_enter", state_o, 1);
    check("load_ready", host_ready, 1);
    for (int i = 0; i < n; i++) begin
      host_valid = 1'b1;
      host_data  = 9'($urandom);
      host_last  = use_last && (i == n - 1);
      if (i < k) sent.push_back(host_data);
      if (i == 8) begin
        check("full_clr_state", state_o, 2);
        check("full_not_ready", host_ready, 0);
        check("full_cpu_reset", cpu_reset, 1);
      end
      tick();
    end
    host_valid = 1'b0;
    host_last  = 1'b0;
    if (n <= 8) begin
      check("clr_state", state_o, 2);
      check("clr_cpu_reset", cpu_reset, 1);
      tick();
    end
    check("load_idle", state_o, 0);
    check("load_cpu_reset_off", cpu_reset, 0);
    check("load_nwr", wr_addr_q.size() - w0, k);
    for (int j = 0; j < k; j++) begin
      if (w0 + j < wr_addr_q.size()) begin
        check("load_addr", wr_addr_q[w0 + j], j);
        check("load_data", wr_data_q[w0 + j], sent[j]);
      end
    end
    m_pc = 0;
    check("load_pc", cpu_pc, m_pc);
  endtask

  task automatic run_check(input int lim, input bit bv, input int b, input bit from_halt);
    int n, cause, c0, e0;
    c0 = from_halt ? m_count : 0;
    predict(m_pc, c0, lim, bv, b, from_halt, n, cause);
    cycle_limit = 8'(lim);
    bkpt_valid  = bv;
    bkpt_addr   = 3'(b);
    e0 = en_cnt;
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    wait_halt("run");
    m_count = (c0 + n > 255) ? 255 : c0 + n;
    m_pc    = (m_pc + n) % 8;
    check("run_en_cycles", en_cnt - e0, n);
    check("run_cause", halt_cause, cause);
    check("run_count", cycle_count, m_count);
    check("run_pc", cpu_pc, m_pc);
    bkpt_valid = 1'b0;
  endtask

  task automatic step_check();
    int e0;
    e0 = en_cnt;
    cmd_step = 1'b1;
    tick();
    cmd_step = 1'b0;
    check("step_state", state_o, 4);
    cmd_halt = 1'b1;
    tick();
    cmd_halt = 1'b0;
    m_count = (m_count < 255) ? m_count + 1 : 255;
    m_pc    = (m_pc + 1) % 8;
    check("step_halt", state_o, 5);
    check("step_cause", halt_cause, 3);
    check("step_en", en_cnt - e0, 1);
    check("step_count", cycle_count, m_count);
    check("step_pc", cpu_pc, m_pc);
  endtask

  task automatic halt_cmd_check(input int d);
    int e0;
    cycle_limit = '0;
    bkpt_valid  = 1'b0;
    e0 = en_cnt;
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    for (int i = 0; i < d; i++) begin
      cmd_load = (i == 0);
      tick();
      cmd_load = 1'b0;
      check("run_ignores_cmd", state_o, 3);
    end
    m_count = (m_count + d > 255) ? 255 : m_count + d;
    m_pc    = (m_pc + d) % 8;
    cmd_halt   = 1'b1;
    bkpt_valid = 1'b1;
    bkpt_addr  = 3'(m_pc);
    tick();
    cmd_halt   = 1'b0;
    bkpt_valid = 1'b0;
    check("hcmd_state", state_o, 5);
    check("hcmd_cause", halt_cause, 0);
    check("hcmd_en", en_cnt - e0, d);
    check("hcmd_count", cycle_count, m_count);
    check("hcmd_pc", cpu_pc, m_pc);
  endtask

  initial begin
    reset = 1'b0;
    tick();
    tick();
    check("rst_state", state_o, 0);
    check("rst_pc_enable", pc_enable, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_ready", host_ready, 0);
    check("rst_wr_en", ram_wr_en, 0);
    check("rst_count", cycle_count, 0);
    check("rst_cause", halt_cause, 0);
    reset = 1'b1;
    tick();
    check("post_rst_cpu_reset", cpu_reset, 0);

    do_load(3, 1'b1, 1'b0);
    do_load(9, 1'b0, 1'b0);
    run_check(5, 1'b0, 0, 1'b0);

    // Breakpoint at 3 with a fallback limit, then resume past it.
    do_load(2, 1'b1, 1'b1);
    run_check(20, 1'b1, 3, 1'b0);
    run_check(m_count + 6, 1'b1, 3, 1'b1);
    step_check();
    step_check();
    halt_cmd_check(3);

    for (int it = 0; it < 6; it++) begin
      int n, b;
      bit bv, ul;
      n  = $urandom_range(1, 9);
      ul = (n < 8) ? 1'b1 : ((n == 8) ? 1'($urandom_range(0, 1)) : 1'b0);
      do_load(n, ul, 1'($urandom_range(0, 1)));
      bv = 1'($urandom_range(0, 1));
      b  = $urandom_range(0, 7);
      run_check($urandom_range(1, 12), bv, b, 1'b0);
      run_check(m_count + $urandom_range(1, 6), bv, b, 1'b1);
      step_check();
      halt_cmd_check($urandom_range(1, 5));
    end

    // Reset while running.
    cycle_limit = '0;
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("midrun_state", state_o, 0);
    check("midrun_pc_enable", pc_enable, 0);
    check("midrun_cpu_reset", cpu_reset, 1);
    check("midrun_count", cycle_count, 0);
    check("midrun_cause", halt_cause, 0);
    reset = 1'b1;
    tick();
    check("midrun_after_state", state_o, 0);
    check("midrun_after_pc", cpu_pc, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
